button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Front-end conditioning for the raw push-buttons that drive player movement and firing.
- Synchronises each asynchronous button input, debounces it, and emits one-cycle press pulses. Optional hold-to-repeat auto-fires pulses while a button stays held.
- Sits directly upstream of the movement/bullet stage. Its btn_pulse bits drive that stage's bt_W / bt_S / bt_J inputs, so each physical press moves the player exactly once, not once per clock.

Parameters:
- N_BTN, 3: number of buttons. Bit 0 = W, bit 1 = S, bit 2 = J.
- DEBOUNCE_CYCLES, 1000000: consecutive cycles of a stable new value required before the debounced level changes (10 ms at 100 MHz). Must be >= 1.
- REPEAT_DELAY, 50000000: cycles from the press pulse to the first repeat pulse. Must be >= 1.
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat pulses. Must be >= 1.
- REPEAT_EN, 3'b011: per-button repeat enable. Default: W and S repeat, J fires once per press.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- btn_raw  in  N_BTN  raw, asynchronous, bouncing button levels (1 = pressed).
- btn_level  out  N_BTN  debounced level.
- btn_pulse  out  N_BTN  one-cycle press/repeat strobe.
- btn_release  out  N_BTN  one-cycle strobe on debounced release.

Behaviour:
- One clock, clk. Reset rstn is asynchronous and active-low.
- Reset clears all state: sync flops, counters, FSMs.
  - btn_level = 0, btn_pulse = 0, btn_release = 0.
  - Reset asserted mid-press or mid-repeat drops all outputs immediately. No pulse is emitted on reset deassertion.
- Channels are fully independent. Simultaneous events on different bits never interact.
- Synchroniser: two flops per bit (sync1 -> sync2), reset to 0. Only sync2 is used downstream.
- Debounce, per channel: counter deb_cnt, width clog2(DEBOUNCE_CYCLES+1).
  - At each edge where sync2 != level: if deb_cnt == DEBOUNCE_CYCLES-1, level toggles and deb_cnt clears; otherwise deb_cnt increments.
  - At any edge where sync2 == level: deb_cnt clears. A glitch shorter than DEBOUNCE_CYCLES therefore never changes level.
  - Latency: raw change first sampled at edge E1 -> btn_level changes after edge E(2+DEBOUNCE_CYCLES).
- Per-channel FSM, states IDLE, HELD, DELAY, REPEAT, with timer rep_cnt wide enough for max(REPEAT_DELAY, REPEAT_PERIOD).
  - IDLE: on level 0->1, assert btn_pulse in the same cycle level first reads 1 (call it cycle P). Clear rep_cnt. Go to DELAY if REPEAT_EN bit set, else HELD.
  - HELD: wait for release.
  - DELAY: rep_cnt increments. At rep_cnt == REPEAT_DELAY-1, pulse (cycle P+REPEAT_DELAY), clear rep_cnt, go to REPEAT.
  - REPEAT: at rep_cnt == REPEAT_PERIOD-1, pulse and clear rep_cnt. Pulses land at P+REPEAT_DELAY+k*REPEAT_PERIOD.
  - Any state with level 1->0: btn_release for one cycle (the cycle level first reads 0), return to IDLE, no btn_pulse that cycle. Release wins over a coincident repeat tick.
- btn_pulse and btn_release are registered, never both high on one bit, and never high for two consecutive cycles. Exception: REPEAT_PERIOD == 1 gives a continuous strobe, which is legal.
- Counters saturate-free: they clear before overflow by construction. No wrap-around is reachable.

Decomposition:
- Shared game package holds:
  - Button index constants: BTN_W = 0, BTN_S = 1, BTN_J = 2.
  - Default timing constants (DEBOUNCE_10MS_100MHZ, REPEAT_DELAY_500MS, REPEAT_PERIOD_100MS).
  - Repeat-FSM state enum.
- One sub-module, btn_channel: synchroniser, debounce counter and repeat FSM for a single button.
- button_conditioner generates N_BTN instances and slices REPEAT_EN per instance.

Test Plan (bench params: DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3):
- Clean press of bit 0 held 40 cycles, first sampled at edge E1 -> btn_level[0] rises after E6; btn_pulse[0] in that cycle P, then at P+10, P+13, P+16, ...; btn_release[0] once after release + 6 edges.
- Bounce on bit 2: 1,0,1,1,0 cycles, then stable high -> exactly one btn_pulse[2]; no repeat pulses while held 50 cycles (REPEAT_EN[2] = 0); level stays 0 during the bounce.
- Glitch of 3 cycles high on bit 1 -> btn_level, btn_pulse, btn_release all remain 0.
- W and S pressed in the same cycle, S released 2 cycles later than W -> each bit shows an identical pulse sequence offset as expected; no cross-talk.
- Release timed to coincide with the P+13 repeat tick -> btn_release asserted, no btn_pulse that cycle; FSM in IDLE; next press pulses normally.
- rstn pulled low asynchronously mid-REPEAT (between edges) -> all outputs 0 immediately. After rstn deasserts with the button still held, btn_pulse fires once after 2+4 edges (fresh press).

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button front end: button indices, default
// timing at 100 MHz and the per-channel repeat state encoding.
package button_conditioner_pkg;

   localparam int BTN_W = 0;
   localparam int BTN_S = 1;
   localparam int BTN_J = 2;

   localparam int DEBOUNCE_10MS_100MHZ = 1000000;
   localparam int REPEAT_DELAY_500MS   = 50000000;
   localparam int REPEAT_PERIOD_100MS  = 10000000;

   // Movement buttons auto-repeat, fire does not.
   localparam logic [2:0] REPEAT_EN_DEFAULT = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HELD,
      ST_DELAY,
      ST_REPEAT
   } rep_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw pad inputs and the conditioned strobes.
interface button_conditioner_if #(
   parameter int N_BTN = 3
);
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_pulse;
   logic [N_BTN-1:0] btn_release;

   modport master (
      output btn_raw,
      input  btn_level,
      input  btn_pulse,
      input  btn_release
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output btn_pulse,
      output btn_release
   );
endinterface

// File: rtl/button_conditioner_btn_channel.sv
// One button: two-flop synchroniser, debounce counter and hold-to-repeat FSM,
// with every output driven straight from a flop.
module btn_channel
   import button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS,
   parameter bit REPEAT_ON       = 1'b0
) (
   input  logic clk,
   input  logic rstn,
   input  logic raw,
   output logic level,
   output logic pulse,
   output logic release_strobe
);

   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int REP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

   localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

   logic             sync1;
   logic             sync2;
   logic [DEB_W-1:0] deb_cnt;
   logic [REP_W-1:0] rep_cnt;
   rep_state_t       state;

   logic deb_flip;
   logic rise;
   logic fall;

   // The FSM reacts to the flip decision itself, so the press pulse lands in
   // the same cycle the debounced level first reads 1.
   always_comb begin
      deb_flip = (sync2 != level) && (deb_cnt == DEB_LAST);
      rise     = deb_flip && !level;
      fall     = deb_flip && level;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1          <= 1'b0;
         sync2          <= 1'b0;
         level          <= 1'b0;
         deb_cnt        <= '0;
         rep_cnt        <= '0;
         state          <= ST_IDLE;
         pulse          <= 1'b0;
         release_strobe <= 1'b0;
      end else begin
         sync1          <= raw;
         sync2          <= sync1;
         pulse          <= 1'b0;
         release_strobe <= 1'b0;

         if (sync2 == level) begin
            deb_cnt <= '0;
         end else if (deb_flip) begin
            deb_cnt <= '0;
            level   <= sync2;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end

         // Release takes priority over any repeat tick in the same cycle.
         if (fall) begin
            release_strobe <= 1'b1;
            rep_cnt        <= '0;
            state          <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (rise) begin
                     pulse   <= 1'b1;
                     rep_cnt <= '0;
                     state   <= REPEAT_ON ? ST_DELAY : ST_HELD;
                  end
               end
               ST_HELD: begin
                  rep_cnt <= '0;
               end
               ST_DELAY: begin
                  if (rep_cnt == DELAY_LAST) begin
                     pulse   <= 1'b1;
                     rep_cnt <= '0;
                     state   <= ST_REPEAT;
                  end else begin
                     rep_cnt <= rep_cnt + 1'b1;
                  end
               end
               ST_REPEAT: begin
                  if (rep_cnt == PERIOD_LAST) begin
                     pulse   <= 1'b1;
                     rep_cnt <= '0;
                  end else begin
                     rep_cnt <= rep_cnt + 1'b1;
                  end
               end
               default: begin
                  rep_cnt <= '0;
                  state   <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw push-buttons into debounced levels plus one-cycle
// press/repeat and release strobes; channels are fully independent.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int               N_BTN           = 3,
   parameter int               DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
   parameter int               REPEAT_DELAY    = REPEAT_DELAY_500MS,
   parameter int               REPEAT_PERIOD   = REPEAT_PERIOD_100MS,
   parameter logic [N_BTN-1:0] REPEAT_EN       = REPEAT_EN_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rstn,
   button_conditioner_if.slave  bus
);

   logic [N_BTN-1:0] level;
   logic [N_BTN-1:0] pulse;
   logic [N_BTN-1:0] release_strobe;

   generate
      for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
         btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_ON       (REPEAT_EN[gi])
         ) u_ch (
            .clk            (clk),
            .rstn           (rstn),
            .raw            (bus.btn_raw[gi]),
            .level          (level[gi]),
            .pulse          (pulse[gi]),
            .release_strobe (release_strobe[gi])
         );
      end
   endgenerate

   assign bus.btn_level   = level;
   assign bus.btn_pulse   = pulse;
   assign bus.btn_release = release_strobe;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: expected strobe times come from the timing rules and
// are scoreboarded per cycle; press vectors are also checked by count.
module tb_button_conditioner;

   localparam int         DEB    = 4;
   localparam int         RD     = 10;
   localparam int         RP     = 3;
   localparam logic [2:0] REP_EN = 3'b011;

   typedef enum int {K_PRESS, K_REPEAT, K_REL} kind_t;
   typedef struct {
      int    cyc;
      int    bidx;
      kind_t kind;
   } ev_t;
   typedef struct {
      int bidx;
      int hold;
      int exp_pulses;
      int exp_rels;
   } vec_t;

   logic clk;
   logic rstn;
   int   cyc;
   int   tests;
   int   fails;
   bit   mon_en;
   logic [2:0] exp_level;
   int   obs_pulses [3];
   int   obs_rels   [3];
   ev_t  sb [$];
   vec_t vecs [8];

   button_conditioner_if #(.N_BTN(3)) bus ();

   button_conditioner #(
      .N_BTN           (3),
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP),
      .REPEAT_EN       (REP_EN)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // tp: first edge sampling the pressed level; tr: first edge sampling the
   // release (or the observation horizon when with_rel is 0).
   task automatic schedule(input int b, input int tp, input int tr, input bit with_rel);
      int tick;
      if (tr - tp < DEB) return;
      sb.push_back('{tp + DEB + 1, b, K_PRESS});
      if (REP_EN[b]) begin
         tick = tp + DEB + 1 + RD;
         while (tick < tr + DEB + 1) begin
            sb.push_back('{tick, b, K_REPEAT});
            tick += RP;
         end
      end
      if (with_rel) sb.push_back('{tr + DEB + 1, b, K_REL});
   endtask

   task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, required %b", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      logic [2:0] ep;
      logic [2:0] er;
      if (mon_en) begin
         ep = '0;
         er = '0;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
               case (sb[i].kind)
                  K_PRESS:  begin ep[sb[i].bidx] = 1'b1; exp_level[sb[i].bidx] = 1'b1; end
                  K_REPEAT: ep[sb[i].bidx] = 1'b1;
                  default:  begin er[sb[i].bidx] = 1'b1; exp_level[sb[i].bidx] = 1'b0; end
               endcase
               sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
               fails++;
               $display("FAIL missed event: bit %0d kind %0d due cyc %0d, now %0d",
                        sb[i].bidx, sb[i].kind, sb[i].cyc, cyc);
               sb.delete(i);
            end
         end
         tests++;
         if (bus.btn_pulse !== ep || bus.btn_release !== er || bus.btn_level !== exp_level) begin
            fails++;
            $display("FAIL outputs cyc %0d: got pulse=%b release=%b level=%b, required pulse=%b release=%b level=%b",
                     cyc, bus.btn_pulse, bus.btn_release, bus.btn_level, ep, er, exp_level);
         end else if ((ep | er) != 3'b000) begin
            $display("[TB] cyc %0d pulse=%b release=%b level=%b", cyc, ep, er, exp_level);
         end
         for (int b = 0; b < 3; b++) begin
            obs_pulses[b] += int'(bus.btn_pulse[b]);
            obs_rels[b]   += int'(bus.btn_release[b]);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int c;
      int tp;
      int bpat [5];

      tests = 0;
      fails = 0;
      mon_en = 1'b0;
      exp_level = '0;
      for (int b = 0; b < 3; b++) begin
         obs_pulses[b] = 0;
         obs_rels[b]   = 0;
      end
      rstn = 1'b0;
      bus.btn_raw = '0;

      vecs[0] = '{0, 40, 11, 1};
      vecs[1] = '{1, 12,  2, 1};
      vecs[2] = '{2, 40,  1, 1};
      vecs[3] = '{0, 10,  1, 1};
      vecs[4] = '{1, 11,  2, 1};
      vecs[5] = '{0,  4,  1, 1};
      vecs[6] = '{1,  3,  0, 0};
      vecs[7] = '{2,  4,  1, 1};

      repeat (3) @(negedge clk);
      chk("reset level",   bus.btn_level,   3'b000);
      chk("reset pulse",   bus.btn_pulse,   3'b000);
      chk("reset release", bus.btn_release, 3'b000);
      rstn = 1'b1;
      mon_en = 1'b1;
      repeat (5) @(negedge clk);

      // Single presses of varying hold length.
      for (int v = 0; v < 8; v++) begin
         for (int b = 0; b < 3; b++) begin
            obs_pulses[b] = 0;
            obs_rels[b]   = 0;
         end
         c = cyc;
         bus.btn_raw[vecs[v].bidx] = 1'b1;
         schedule(vecs[v].bidx, c + 1, c + 1 + vecs[v].hold, 1'b1);
         repeat (vecs[v].hold) @(negedge clk);
         bus.btn_raw[vecs[v].bidx] = 1'b0;
         repeat (12) @(negedge clk);
         chk_int($sformatf("vec%0d pulses", v),   obs_pulses[vecs[v].bidx], vecs[v].exp_pulses);
         chk_int($sformatf("vec%0d releases", v), obs_rels[vecs[v].bidx],   vecs[v].exp_rels);
      end

      // Bounce on J, then a long stable hold with no repeats.
      bpat = '{1, 0, 1, 1, 0};
      obs_pulses[2] = 0;
      for (int i = 0; i < 5; i++) begin
         bus.btn_raw[2] = bpat[i][0];
         @(negedge clk);
      end
      c = cyc;
      bus.btn_raw[2] = 1'b1;
      schedule(2, c + 1, c + 51, 1'b1);
      repeat (50) @(negedge clk);
      bus.btn_raw[2] = 1'b0;
      repeat (12) @(negedge clk);
      chk_int("bounce J pulses", obs_pulses[2], 1);

      // Glitch of three cycles on S.
      bus.btn_raw[1] = 1'b1;
      repeat (3) @(negedge clk);
      bus.btn_raw[1] = 1'b0;
      repeat (10) @(negedge clk);

      // W and S together, S released two cycles after W.
      c = cyc;
      tp = c + 1;
      bus.btn_raw[1:0] = 2'b11;
      schedule(0, tp, tp + 20, 1'b1);
      schedule(1, tp, tp + 22, 1'b1);
      repeat (20) @(negedge clk);
      bus.btn_raw[0] = 1'b0;
      repeat (2) @(negedge clk);
      bus.btn_raw[1] = 1'b0;
      repeat (12) @(negedge clk);

      // Release coinciding with the P+13 repeat tick, then a normal re-press.
      c = cyc;
      bus.btn_raw[0] = 1'b1;
      schedule(0, c + 1, c + 14, 1'b1);
      repeat (13) @(negedge clk);
      bus.btn_raw[0] = 1'b0;
      repeat (10) @(negedge clk);
      c = cyc;
      bus.btn_raw[0] = 1'b1;
      schedule(0, c + 1, c + 13, 1'b1);
      repeat (12) @(negedge clk);
      bus.btn_raw[0] = 1'b0;
      repeat (12) @(negedge clk);

      // Asynchronous reset in the middle of REPEAT with W still held.
      c = cyc;
      tp = c + 1;
      bus.btn_raw[0] = 1'b1;
      schedule(0, tp, tp + 15, 1'b0);
      while (cyc < tp + 19) @(negedge clk);
      chk("pre-reset level", bus.btn_level, 3'b001);
      mon_en = 1'b0;
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      chk("async reset level",   bus.btn_level,   3'b000);
      chk("async reset pulse",   bus.btn_pulse,   3'b000);
      chk("async reset release", bus.btn_release, 3'b000);
      chk_int("pending before reset", sb.size(), 0);
      sb.delete();
      exp_level = '0;
      repeat (2) @(negedge clk);
      c = cyc;
      rstn = 1'b1;
      mon_en = 1'b1;
      schedule(0, c + 1, c + 9, 1'b1);
      repeat (8) @(negedge clk);
      bus.btn_raw[0] = 1'b0;
      repeat (12) @(negedge clk);

      mon_en = 1'b0;
      chk_int("scoreboard drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
